// File: rtl/spi_config_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_config_master
// Description : Two-requester round-robin SPI write master (16-bit mode-0
//               frames: write flag, 7-bit address, 8-bit data, MSB first).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_config_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    output logic       busy,
    output logic       done,
    output logic       grant_id
);

    localparam int c_MAX_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_MAX_B  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int c_MAX    = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W  = $clog2(c_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LD_DIV   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(CS_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_LD_IDLE  = c_CNT_W'(CS_IDLE - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SETUP    = 3'd1;
    localparam logic [2:0] c_ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] c_ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] c_ST_HOLD     = 3'd4;
    localparam logic [2:0] c_ST_GAP      = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit_idx;
    logic [15:0]        r_frame;
    logic               r_last;
    logic               r_ncs;
    logic               r_sclk;
    logic               r_copi;
    logic               r_done;
    logic               r_grant;

    logic               w_idle;
    logic               w_winner;
    logic               w_accept;
    logic [15:0]        w_frame;
    logic [3:0]         w_next_idx;
    logic               w_cnt_end;

    // On a tie the requester that was not granted last wins.
    assign w_winner   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_idle     = (r_state == c_ST_IDLE);
    assign req0_ready = w_idle & ~rst & req0_valid & ~w_winner;
    assign req1_ready = w_idle & ~rst & req1_valid &  w_winner;
    assign w_accept   = req0_ready | req1_ready;
    assign w_frame    = w_winner ? {1'b1, req1_addr, req1_data}
                                 : {1'b1, req0_addr, req0_data};
    assign w_next_idx = r_bit_idx + 4'd1;
    assign w_cnt_end  = (r_cnt == c_CNT_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= c_CNT_ZERO;
            r_bit_idx <= 4'd0;
            r_frame   <= 16'd0;
            r_last    <= 1'b1;
            r_ncs     <= 1'b1;
            r_sclk    <= 1'b0;
            r_copi    <= 1'b0;
            r_done    <= 1'b0;
            r_grant   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_frame <= w_frame;
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_ncs   <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_copi  <= 1'b1;
                        r_cnt   <= c_LD_SETUP;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (w_cnt_end) begin
                        r_bit_idx <= 4'd0;
                        r_copi    <= r_frame[15];
                        r_cnt     <= c_LD_DIV;
                        r_state   <= c_ST_SHIFT_LO;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_SHIFT_LO: begin
                    if (w_cnt_end) begin
                        r_sclk  <= 1'b1;
                        r_cnt   <= c_LD_DIV;
                        r_state <= c_ST_SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_SHIFT_HI: begin
                    if (w_cnt_end) begin
                        r_sclk <= 1'b0;
                        if (r_bit_idx == 4'd15) begin
                            r_cnt   <= c_LD_HOLD;
                            r_state <= c_ST_HOLD;
                        end else begin
                            // Next bit is presented on the falling edge.
                            r_bit_idx <= w_next_idx;
                            r_copi    <= r_frame[4'd15 - w_next_idx];
                            r_cnt     <= c_LD_DIV;
                            r_state   <= c_ST_SHIFT_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_HOLD: begin
                    if (w_cnt_end) begin
                        r_ncs   <= 1'b1;
                        r_copi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= c_LD_IDLE;
                        r_state <= c_ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_GAP: begin
                    if (w_cnt_end) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_ncs   <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_copi  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ncs      = r_ncs;
    assign sclk     = r_sclk;
    assign copi     = r_copi;
    assign done     = r_done;
    assign grant_id = r_grant;
    assign busy     = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_spi_config_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_config_master
// Description : Self-checking bench: SPI receiver monitor plus a register and
//               arbitration model compared against the captured frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_config_master;

    localparam int c_CLK_DIV  = 4;
    localparam int c_CS_SETUP = 4;
    localparam int c_CS_HOLD  = 4;
    localparam int c_CS_IDLE  = 4;
    localparam int c_NCS_LOW  = c_CS_SETUP + 32 * c_CLK_DIV + c_CS_HOLD;
    localparam int c_RISE_OFS = c_CS_SETUP + c_CLK_DIV;
    localparam int c_BUDGET   = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [6:0] req0_addr = '0, req1_addr = '0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       ncs, sclk, copi, busy, done, grant_id;

    always #5 clk = ~clk;

    spi_config_master #(
        .CLK_DIV (c_CLK_DIV),
        .CS_SETUP(c_CS_SETUP),
        .CS_HOLD (c_CS_HOLD),
        .CS_IDLE (c_CS_IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi),
        .busy      (busy),
        .done      (done),
        .grant_id  (grant_id)
    );

    int checks = 0;
    int errors = 0;

    // Receiver-side monitor state
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] mon_sh = '0;
    int          mon_bits = 0, mon_low = 0, mon_first = -1, mon_high = 0;
    int          min_gap = 1000, done_cnt = 0, done_bad = 0, sclk_bad = 0;
    int          rdy0_cnt = 0, rdy1_cnt = 0, aborted = 0;
    logic [15:0] cap_frames[$];
    int          cap_low[$], cap_first[$];
    logic [7:0]  act_regs[5];

    // Reference model state
    logic [15:0] exp_frames[$];
    int          exp_order[$], act_order[$];
    logic [7:0]  exp_regs[5];
    bit          last_model = 1'b1;
    bit          exp_grant  = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (!(ncs && !prev_ncs)) done_bad++;
        end
        if (req0_valid && req0_ready) rdy0_cnt++;
        if (req1_valid && req1_ready) rdy1_cnt++;
        if (prev_ncs && !ncs) begin
            if (mon_high < min_gap) min_gap = mon_high;
            mon_bits = 0; mon_sh = '0; mon_low = 0; mon_first = -1;
        end
        if (!ncs) begin
            mon_low++;
            if (sclk && !prev_sclk) begin
                if (mon_bits == 0) mon_first = mon_low - 1;
                mon_sh = {mon_sh[14:0], copi};
                mon_bits++;
            end
        end else if (sclk) begin
            sclk_bad++;
        end
        if (!prev_ncs && ncs) begin
            if (mon_bits == 16) begin
                cap_frames.push_back(mon_sh);
                cap_low.push_back(mon_low);
                cap_first.push_back(mon_first);
                if (mon_sh[15] && mon_sh[14:8] <= 7'd4) act_regs[int'(mon_sh[14:8])] = mon_sh[7:0];
            end else begin
                aborted++;
            end
            mon_high = 0;
        end
        if (ncs) mon_high++;
        prev_ncs  = ncs;
        prev_sclk = sclk;
    end

    task automatic model_write(input bit port, input logic [6:0] a, input logic [7:0] d);
        exp_order.push_back(int'(port));
        exp_frames.push_back({1'b1, a, d});
        if (a <= 7'd4) exp_regs[int'(a)] = d;
        last_model = port;
        exp_grant  = port;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < c_BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frames(input string tag);
        logic [15:0] ef, af;
        int v, eo;
        while (exp_frames.size() > 0) begin
            ef = exp_frames.pop_front();
            checks++;
            if (cap_frames.size() == 0) begin
                errors++;
                $display("FAIL %s frame_missing: got none, required %h", tag, ef);
            end else begin
                af = cap_frames.pop_front();
                if (af !== ef) begin
                    errors++;
                    $display("FAIL %s frame: got %h required %h", tag, af, ef);
                end
                checks++;
                v = cap_low.pop_front();
                if (v != c_NCS_LOW) begin
                    errors++;
                    $display("FAIL %s ncs_low_len: got %0d required %0d", tag, v, c_NCS_LOW);
                end
                checks++;
                v = cap_first.pop_front();
                if (v != c_RISE_OFS) begin
                    errors++;
                    $display("FAIL %s first_rise: got %0d required %0d", tag, v, c_RISE_OFS);
                end
            end
        end
        checks++;
        if (cap_frames.size() != 0) begin
            errors++;
            $display("FAIL %s extra_frames: got %0d required 0", tag, cap_frames.size());
        end
        cap_frames.delete(); cap_low.delete(); cap_first.delete();
        while (exp_order.size() > 0) begin
            eo = exp_order.pop_front();
            checks++;
            if (act_order.size() == 0) begin
                errors++;
                $display("FAIL %s grant_order: got none required %0d", tag, eo);
            end else begin
                v = act_order.pop_front();
                if (v != eo) begin
                    errors++;
                    $display("FAIL %s grant_order: got %0d required %0d", tag, v, eo);
                end
            end
        end
        act_order.delete();
        checks++;
        if (grant_id !== exp_grant) begin
            errors++;
            $display("FAIL %s grant_id: got %0b required %0b", tag, grant_id, exp_grant);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (act_regs[i] !== exp_regs[i]) begin
                errors++;
                $display("FAIL %s reg%0d: got %h required %h", tag, i, act_regs[i], exp_regs[i]);
            end
        end
    endtask

    // Drives one or both requesters at once and records the accept order.
    task automatic run_pair(input bit v0, input logic [6:0] a0, input logic [7:0] d0,
                            input bit v1, input logic [6:0] a1, input logic [7:0] d1);
        bit p0 = v0, p1 = v1, acc0, acc1;
        int n = 0;
        if (v0 && v1) begin
            if (last_model) begin model_write(1'b0, a0, d0); model_write(1'b1, a1, d1); end
            else            begin model_write(1'b1, a1, d1); model_write(1'b0, a0, d0); end
        end else if (v0) model_write(1'b0, a0, d0);
        else if (v1)     model_write(1'b1, a1, d1);
        @(negedge clk);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        while ((p0 || p1) && n < c_BUDGET) begin
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (acc0) begin req0_valid = 1'b0; p0 = 1'b0; act_order.push_back(0); end
            if (acc1) begin req1_valid = 1'b0; p1 = 1'b0; act_order.push_back(1); end
            @(negedge clk);
            n++;
        end
        checks++;
        if (p0 || p1) begin
            errors++;
            $display("FAIL accept_timeout: pending0=%0b pending1=%0b required 0 0", p0, p1);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        wait_idle();
    endtask

    task automatic wait_ready(input bit port, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < c_BUDGET) begin
            #1;
            if ((port ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ready_timeout: port %0d got no ready, required ready", port);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks += 8;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %0b required 0", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %0b required 0", req1_ready); end
        if (ncs !== 1'b1)        begin errors++; $display("FAIL rst_ncs: got %0b required 1", ncs); end
        if (sclk !== 1'b0)       begin errors++; $display("FAIL rst_sclk: got %0b required 0", sclk); end
        if (copi !== 1'b0)       begin errors++; $display("FAIL rst_copi: got %0b required 0", copi); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %0b required 0", done); end
        if (grant_id !== 1'b0)   begin errors++; $display("FAIL rst_grant: got %0b required 0", grant_id); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        last_model = 1'b1; exp_grant = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        run_pair(1'b1, 7'h04, 8'h80, 1'b0, 7'h00, 8'h00);
        checks++;
        if (cap_frames.size() == 0 || cap_frames[0] !== 16'h8480) begin
            errors++;
            $display("FAIL single_frame: got %h required 8480", (cap_frames.size() != 0) ? cap_frames[0] : 16'hxxxx);
        end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done: got %0d required 1", done_cnt - d0); end
        check_frames("single");
    endtask

    task automatic test_tie();
        run_pair(1'b1, 7'h00, 8'hA5, 1'b1, 7'h01, 8'h5A);
        check_frames("tie1");
        for (int k = 0; k < 3; k++) begin
            run_pair(1'b1, 7'($urandom_range(0, 4)), 8'($urandom),
                     1'b1, 7'($urandom_range(0, 4)), 8'($urandom));
            check_frames("tie_rand");
        end
    endtask

    task automatic test_back_to_back();
        int r0 = rdy1_cnt, d0 = done_cnt;
        bit ok;
        logic [6:0] a;
        logic [7:0] d;
        min_gap = 1000;
        @(negedge clk);
        req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 7'($urandom_range(0, 4));
            d = 8'($urandom);
            req1_addr = a; req1_data = d;
            model_write(1'b1, a, d);
            wait_ready(1'b1, ok);
            if (!ok) break;
            @(posedge clk);
            #1;
            act_order.push_back(1);
            if (k == 2) req1_valid = 1'b0;
            @(negedge clk);
        end
        req1_valid = 1'b0;
        wait_idle();
        checks += 3;
        if (rdy1_cnt - r0 != 3) begin errors++; $display("FAIL b2b_ready: got %0d required 3", rdy1_cnt - r0); end
        if (done_cnt - d0 != 3) begin errors++; $display("FAIL b2b_done: got %0d required 3", done_cnt - d0); end
        if (min_gap < c_CS_IDLE + 1) begin errors++; $display("FAIL b2b_gap: got %0d required >= %0d", min_gap, c_CS_IDLE + 1); end
        check_frames("b2b");
    endtask

    task automatic test_busy_lockout();
        bit ok;
        int viol = 0, n = 0;
        logic [6:0] a;
        logic [7:0] d;
        a = 7'($urandom_range(0, 4)); d = 8'($urandom);
        @(negedge clk);
        req1_valid = 1'b1; req1_addr = a; req1_data = d;
        model_write(1'b1, a, d);
        wait_ready(1'b1, ok);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        act_order.push_back(1);
        repeat (20) @(negedge clk);
        a = 7'($urandom_range(0, 4)); d = 8'($urandom);
        req0_valid = 1'b1; req0_addr = a; req0_data = d;
        model_write(1'b0, a, d);
        while (n < c_BUDGET) begin
            @(negedge clk);
            #1;
            if (!busy) break;
            if (req0_ready) viol++;
            n++;
        end
        checks += 2;
        if (viol != 0) begin errors++; $display("FAIL lock_ready_while_busy: got %0d cycles required 0", viol); end
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL lock_first_idle_ready: got %0b required 1", req0_ready); end
        @(posedge clk);
        #1;
        act_order.push_back(0);
        @(negedge clk);
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL lock_ready_one_cycle: got %0b required 0", req0_ready); end
        req0_valid = 1'b0;
        wait_idle();
        check_frames("lockout");
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int d0, ab, n = 0;
        logic [7:0] d;
        d = ~exp_regs[4];
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 7'h04; req0_data = d;
        wait_ready(1'b0, ok);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        d0 = done_cnt; ab = aborted;
        while (mon_bits < 7 && n < c_BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 5;
        if (ncs !== 1'b1)  begin errors++; $display("FAIL mid_rst_ncs: got %0b required 1", ncs); end
        if (sclk !== 1'b0) begin errors++; $display("FAIL mid_rst_sclk: got %0b required 0", sclk); end
        if (copi !== 1'b0) begin errors++; $display("FAIL mid_rst_copi: got %0b required 0", copi); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b required 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %0b required 0", done); end
        @(negedge clk);
        rst = 1'b0;
        last_model = 1'b1; exp_grant = 1'b0;
        repeat (40) @(negedge clk);
        checks += 2;
        if (done_cnt != d0)     begin errors++; $display("FAIL mid_rst_no_done: got %0d required %0d", done_cnt, d0); end
        if (aborted != ab + 1)  begin errors++; $display("FAIL mid_rst_aborted: got %0d required %0d", aborted, ab + 1); end
        check_frames("mid_rst");
    endtask

    task automatic test_sweep();
        bit port;
        logic [6:0] a;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            a = (i == 5) ? 7'h7F : 7'(i);
            d = (i == 5) ? 8'hFF : 8'(8'h11 * (i + 1));
            port = 1'($urandom_range(0, 1));
            if (port) run_pair(1'b0, 7'h00, 8'h00, 1'b1, a, d);
            else      run_pair(1'b1, a, d, 1'b0, 7'h00, 8'h00);
        end
        check_frames("sweep");
    endtask

    task automatic test_random();
        bit v0, v1;
        for (int k = 0; k < 6; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_pair(v0, 7'($urandom), 8'($urandom), v1, 7'($urandom), 8'($urandom));
            check_frames("random");
        end
        checks += 2;
        if (done_bad != 0) begin errors++; $display("FAIL done_alignment: got %0d bad pulses required 0", done_bad); end
        if (sclk_bad != 0) begin errors++; $display("FAIL sclk_outside_ncs: got %0d cycles required 0", sclk_bad); end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            act_regs[i] = 8'h00;
            exp_regs[i] = 8'h00;
        end
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_busy_lockout();
        test_reset_midframe();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
